// File: rtl/watch_mode_ctrl_if.sv
// watch_mode_ctrl_if: button inputs and mode/stopwatch/time-adjust outputs of the watch controller
interface watch_mode_ctrl_if #(
    parameter int N_SW  = 2,
    parameter int SEL_W = 3
);
    logic             btn_mode;
    logic             btn_time_set;
    logic             btn_increment;
    logic             btn_decrement;
    logic [2:0]       state;
    logic [SEL_W-1:0] sw_sel;
    logic [N_SW-1:0]  run_sw;
    logic [N_SW-1:0]  reset_sw;
    logic             run_time;
    logic             inc_h;
    logic             dec_h;
    logic             inc_m;
    logic             dec_m;

    modport master (
        output btn_mode, btn_time_set, btn_increment, btn_decrement,
        input  state, sw_sel, run_sw, reset_sw, run_time, inc_h, dec_h, inc_m, dec_m
    );

    modport slave (
        input  btn_mode, btn_time_set, btn_increment, btn_decrement,
        output state, sw_sel, run_sw, reset_sw, run_time, inc_h, dec_h, inc_m, dec_m
    );
endinterface

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: watch mode FSM with N stopwatch channels, set-mode timeout and optional auto-repeat (AUTO_REPEAT_EN)
module watch_mode_ctrl #(
    parameter int N_SW          = 2,
    parameter int SEL_W         = 3,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4,
    parameter int TIMEOUT       = 1024
) (
    input logic              clk,
    input logic              reset,
    watch_mode_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        TIME     = 3'b000,
        SET_H    = 3'b001,
        SET_M    = 3'b010,
        SW_VIEW  = 3'b011,
        SW_RESET = 3'b101
    } state_e;

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sw_sel_q, sw_sel_d;
    logic [N_SW-1:0]  run_sw_q, run_sw_d;
    logic [N_SW-1:0]  reset_sw_q, reset_sw_d;
    logic [N_SW-1:0]  sel_oh;
    logic             run_time_q, run_time_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [3:0]       btn_q, btn, press;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             in_set, tmo_hit, sel_last;
    logic             inc_p, dec_p;
    logic             rep_inc, rep_dec;

    assign btn      = {bus.btn_decrement, bus.btn_increment, bus.btn_time_set, bus.btn_mode};
    assign press    = btn & ~btn_q;
    assign sel_oh   = N_SW'(1) << sw_sel_q;
    assign sel_last = (sw_sel_q == SEL_W'(N_SW - 1));
    assign in_set   = (state_q == SET_H) || (state_q == SET_M);
    assign tmo_hit  = (TIMEOUT != 0) && in_set && (tmo_q == TW'(TIMEOUT));

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_q, rpt_d, rpt_nxt;
    logic          arm_q, arm_d, first_q, first_d;
    logic          keep, start, fire;

    // Repeat timer: armed by a lone inc/dec press, runs while that button stays held alone in the same set mode
    always_comb begin
        keep    = in_set & ~tmo_hit & ~press[1] & (btn[2] ^ btn[3]);
        start   = keep & (press[2] | press[3]);
        rpt_nxt = rpt_q + RW'(1);
        fire    = keep & ~start & arm_q &
                  (rpt_nxt == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
        arm_d   = start | (keep & arm_q);
        first_d = start | (first_q & ~fire);
        rpt_d   = (start | fire | ~keep) ? '0 : rpt_nxt;
    end

    // Repeat timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q   <= '0;
            arm_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            arm_q   <= arm_d;
            first_q <= first_d;
        end
    end

    assign rep_inc = fire & btn[2];
    assign rep_dec = fire & btn[3];
`else
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    // Next mode, stopwatch control, adjust pulses and inactivity counter
    always_comb begin
        state_d    = state_q;
        sw_sel_d   = sw_sel_q;
        run_sw_d   = run_sw_q;
        reset_sw_d = '0;
        pulse_d    = '0;
        inc_p      = 1'b0;
        dec_p      = 1'b0;
        case (state_q)
            TIME: begin
                if (press[0]) begin
                    state_d  = SW_VIEW;
                    sw_sel_d = '0;
                end else if (press[1]) begin
                    state_d = SET_H;
                end
            end
            SET_H, SET_M: begin
                if (tmo_hit) begin
                    state_d = TIME;
                end else begin
                    if (press[1]) state_d = (state_q == SET_H) ? SET_M : TIME;
                    inc_p   = (press[2] & ~press[3]) | rep_inc;
                    dec_p   = (press[3] & ~press[2]) | rep_dec;
                    pulse_d = (state_q == SET_H) ? {inc_p, dec_p, 2'b00} : {2'b00, inc_p, dec_p};
                end
            end
            SW_VIEW: begin
                if (press[2]) begin
                    run_sw_d = run_sw_q ^ sel_oh;
                end else if (press[3]) begin
                    state_d    = SW_RESET;
                    reset_sw_d = sel_oh;
                    run_sw_d   = run_sw_q & ~sel_oh;
                end else if (press[0]) begin
                    state_d  = sel_last ? TIME : SW_VIEW;
                    sw_sel_d = sel_last ? '0 : sw_sel_q + SEL_W'(1);
                end else if (press[1]) begin
                    state_d = SET_H;
                end
            end
            SW_RESET: state_d = SW_VIEW;
            default:  state_d = TIME;
        endcase
        run_time_d = !((state_d == SET_H) || (state_d == SET_M));
        tmo_d = (in_set && !run_time_d && (press == 4'b0) && !(rep_inc || rep_dec)) ?
                tmo_q + TW'(1) : '0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TIME;
            sw_sel_q   <= '0;
            run_sw_q   <= '0;
            reset_sw_q <= '0;
            run_time_q <= 1'b1;
            pulse_q    <= '0;
            btn_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            sw_sel_q   <= sw_sel_d;
            run_sw_q   <= run_sw_d;
            reset_sw_q <= reset_sw_d;
            run_time_q <= run_time_d;
            pulse_q    <= pulse_d;
            btn_q      <= btn;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.sw_sel   = sw_sel_q;
    assign bus.run_sw   = run_sw_q;
    assign bus.reset_sw = reset_sw_q;
    assign bus.run_time = run_time_q;
    assign bus.inc_h    = pulse_q[3];
    assign bus.dec_h    = pulse_q[2];
    assign bus.inc_m    = pulse_q[1];
    assign bus.dec_m    = pulse_q[0];
endmodule

// File: tb/tb_watch_mode_ctrl.sv
// tb_watch_mode_ctrl: scoreboard bench for watch_mode_ctrl with a behavioural mode model
module tb_watch_mode_ctrl;
    localparam int N  = 2;
    localparam int SW = 3;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int TO = 32;

    typedef struct packed {
        logic [2:0]    st;
        logic [SW-1:0] sel;
        logic [N-1:0]  run;
        logic [N-1:0]  rs;
        logic          rt;
        logic [3:0]    pl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_ih = 0;

    int         m_st, m_sel, m_idle, m_hold;
    logic [N-1:0] m_run;
    logic [3:0] m_prev;

    watch_mode_ctrl_if #(.N_SW(N), .SEL_W(SW)) bus ();

    watch_mode_ctrl #(
        .N_SW(N), .SEL_W(SW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: what the outputs must be after the next edge, given reset and buttons {dec,inc,time_set,mode}
    task model_step(input logic r, input logic [3:0] b, output exp_t e);
        logic [3:0]   p;
        logic [N-1:0] rs;
        logic [3:0]   pl;
        int           nst;
        bit           set, tmo, ip, dp, rep;
        rs = '0; pl = '0; ip = 0; dp = 0; rep = 0;
        if (r) begin
            m_st = 0; m_sel = 0; m_run = '0; m_idle = 0; m_hold = -1; m_prev = '0;
        end else begin
            p      = b & ~m_prev;
            m_prev = b;
            set    = (m_st == 1) || (m_st == 2);
            tmo    = set && (TO != 0) && (m_idle == TO);
            nst    = m_st;
            if (!set || tmo) m_hold = -1;
            if (m_st == 0) begin
                if (p[0]) begin nst = 3; m_sel = 0; end
                else if (p[1]) nst = 1;
            end else if (set) begin
                if (tmo) nst = 0;
                else begin
                    if (p[1]) nst = (m_st == 1) ? 2 : 0;
`ifdef AUTO_REPEAT_EN
                    if (nst == m_st && (b[2] ^ b[3])) begin
                        if (p[2] | p[3]) m_hold = 0;
                        else if (m_hold >= 0) begin
                            m_hold++;
                            rep = (m_hold >= RD) && ((m_hold - RD) % RP == 0);
                        end
                    end else m_hold = -1;
`endif
                    ip = (p[2] && !p[3]) || (rep && b[2]);
                    dp = (p[3] && !p[2]) || (rep && b[3]);
                    pl = (m_st == 1) ? {ip, dp, 2'b00} : {2'b00, ip, dp};
                end
            end else if (m_st == 3) begin
                if (p[2]) m_run[m_sel] = ~m_run[m_sel];
                else if (p[3]) begin
                    nst = 5;
                    rs[m_sel] = 1'b1;
                    m_run[m_sel] = 1'b0;
                end else if (p[0]) begin
                    if (m_sel == N - 1) begin nst = 0; m_sel = 0; end
                    else m_sel++;
                end else if (p[1]) nst = 1;
            end else nst = 3;
            m_idle = (set && (nst == 1 || nst == 2) && p == 4'b0 && !rep) ? m_idle + 1 : 0;
            m_st = nst;
        end
        e.st  = 3'(m_st);
        e.sel = SW'(m_sel);
        e.run = m_run;
        e.rs  = rs;
        e.rt  = !(m_st == 1 || m_st == 2);
        e.pl  = pl;
    endtask

    task step(input logic r, input logic [3:0] b);
        exp_t e;
        @(negedge clk);
        reset = r;
        {bus.btn_decrement, bus.btn_increment, bus.btn_time_set, bus.btn_mode} = b;
        model_step(r, b, e);
        q.push_back(e);
    endtask

    task press(input logic [3:0] b);
        step(1'b0, b);
        step(1'b0, 4'b0);
    endtask

    // Monitor: outputs are presented every cycle; compare each against the oldest expectation
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {bus.state, bus.sw_sel, bus.run_sw, bus.reset_sw, bus.run_time,
                     bus.inc_h, bus.dec_h, bus.inc_m, bus.dec_m};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got st=%0d sel=%0d run=%b rs=%b rt=%b pl=%b want st=%0d sel=%0d run=%b rs=%b rt=%b pl=%b",
                             $time, a.st, a.sel, a.run, a.rs, a.rt, a.pl, e.st, e.sel, e.run, e.rs, e.rt, e.pl);
                end
                if (a.pl[3]) n_ih++;
            end
        end
    end

    initial begin
        logic [3:0] b;
        int         want_ih;
        {bus.btn_decrement, bus.btn_increment, bus.btn_time_set, bus.btn_mode} = 4'b0;
        step(1'b1, 4'b0);
        step(1'b1, 4'b0);
        step(1'b0, 4'b0);
        press(4'b0001);
        press(4'b0100);
        press(4'b0001);
        press(4'b0100);
        repeat (3) step(1'b1, 4'b0);
        step(1'b0, 4'b0);
        press(4'b0001);
        press(4'b0100);
        press(4'b0001);
        press(4'b0100);
        press(4'b0001);
        press(4'b0001);
        press(4'b0001);
        press(4'b1000);
        step(1'b0, 4'b0);
        press(4'b0001);
        press(4'b0010);
        @(posedge clk);
        #2;
        n_ih = 0;
        repeat (20) step(1'b0, 4'b0100);
        repeat (3) step(1'b0, 4'b0);
        @(posedge clk);
        #2;
`ifdef AUTO_REPEAT_EN
        want_ih = 4;
`else
        want_ih = 1;
`endif
        n_chk++;
        if (n_ih != want_ih) begin
            n_fail++;
            $display("FAIL hold_inc_h_count got %0d want %0d", n_ih, want_ih);
        end
        press(4'b0010);
        repeat (40) step(1'b0, 4'b0);
        press(4'b0010);
        press(4'b0010);
        press(4'b1100);
        press(4'b0010);
        b = 4'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 399) == 0) step(1'b1, b);
            else if ($urandom_range(0, 249) == 0) begin
                b = 4'b0;
                repeat (40) step(1'b0, b);
            end else begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 5) == 0) b[k] = ~b[k];
                step(1'b0, b);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/watch_mode_ctrl.md
Name: watch_mode_ctrl

Overview:
- Parametrised next-generation watch state controller.
- Adds N independent stopwatch channels with a view selector, rising-edge button detection, auto-repeat on held increment/decrement in set modes, and an inactivity timeout out of set modes.
- Sits between the button synchronisers and the timekeeping, stopwatch and 7-seg blocks.
- Drives mode, time-set pulses and per-channel stopwatch run/reset.

Parameters:
- N_SW, 2, number of stopwatch channels (1..8).
- SEL_W, 3, width of sw_sel; must be >= clog2(N_SW) and >= 1.
- REPEAT_DELAY, 16, cycles a held inc/dec button must stay high before the first auto-repeat pulse (>= 1).
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (>= 1).
- TIMEOUT, 1024, cycles without any button press in SET_H/SET_M before returning to TIME; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  mode button, synchronised level.
- btn_time_set  in  1  time-set button, synchronised level.
- btn_increment  in  1  increment / start-stop button, level.
- btn_decrement  in  1  decrement / reset button, level.
- state  out  3  current mode, to the 7-seg controller.
- sw_sel  out  SEL_W  index of the displayed/controlled stopwatch channel.
- run_sw  out  N_SW  per-channel stopwatch run enables.
- reset_sw  out  N_SW  per-channel one-cycle stopwatch clear.
- run_time  out  1  timekeeping enable.
- inc_h, dec_h, inc_m, dec_m  out  1 each  one-cycle time adjust pulses.

Behaviour:
- One clock; reset is synchronous and active-high. All state and outputs are registered.
- Reset values: state=TIME, sw_sel=0, run_sw=0, reset_sw=0, run_time=1, adjust pulses=0, all counters=0. Reset mid-operation aborts any mode immediately; running channels stop.
- Press detection: press_x = btn_x & ~btn_x_q, where btn_x_q is the previous-cycle level. Only presses, not levels, cause transitions.
- Timing: a press sampled at edge k produces its state change and output pulse at edge k. Pulses are visible for exactly the cycle after edge k.
- State encoding: TIME=3'b000, SET_H=3'b001, SET_M=3'b010, SW_VIEW=3'b011, SW_RESET=3'b101.
- TIME:
  - press_mode -> SW_VIEW with sw_sel=0.
  - Otherwise press_time_set -> SET_H.
  - Mode has priority over time_set.
- SET_H / SET_M:
  - run_time=0 throughout.
  - press_time_set: SET_H -> SET_M; SET_M -> TIME.
  - inc/dec produce inc_h/dec_h in SET_H and inc_m/dec_m in SET_M.
  - Simultaneous inc and dec presses: neither pulses.
  - run_sw is unaffected; stopwatch channels keep running while time is set.
- SW_VIEW:
  - press_increment toggles run_sw[sw_sel].
  - Otherwise press_decrement -> SW_RESET.
  - Otherwise press_mode: sw_sel+1; if sw_sel==N_SW-1, go to TIME with sw_sel=0.
  - Otherwise press_time_set -> SET_H.
- SW_RESET:
  - Lasts one cycle with reset_sw[sw_sel]=1 and run_sw[sw_sel]=0.
  - Then returns to SW_VIEW with the same sw_sel. Button presses during this cycle are ignored.
- run_time=1 in every state except SET_H/SET_M.
- Timeout:
  - A counter runs in SET_H/SET_M and clears on any press or on entering those states.
  - When it reaches TIMEOUT, state goes to TIME on the next edge. No adjust pulse is emitted that cycle.
- sw_sel never exceeds N_SW-1. With N_SW=1, mode from SW_VIEW always returns to TIME.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - In SET_H/SET_M, an inc or dec held high alone emits its first pulse on press.
  - If still held alone after REPEAT_DELAY further cycles, it emits another pulse, then one every REPEAT_PERIOD cycles.
  - Releasing, pressing both buttons, or changing state stops and rearms the repeat.
  - Repeat pulses also clear the timeout counter.
- Undefined: exactly one pulse per press; REPEAT_* parameters are unused and the repeat counter is not synthesised.

Test Plan (N_SW=2, REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=32):
- Reset held 3 cycles mid-SW_VIEW with run_sw=2'b11 -> state=0, run_sw=0, run_time=1, sw_sel=0 the cycle after release.
- TIME, mode press -> state=3, sw_sel=0. Increment press -> run_sw=01. Mode press -> sw_sel=1. Increment press -> run_sw=11. Mode press -> state=0, run_sw stays 11.
- SW_VIEW sw_sel=1 running, decrement press -> reset_sw=10 and run_sw[1]=0 for one cycle, state=5, then state=3, sw_sel=1.
- TIME, time_set press -> 1. Increment held 20 cycles -> with AUTO_REPEAT_EN, inc_h pulses at cycles 1, 9, 13, 17; without it, a single pulse at cycle 1.
- SET_M, no buttons for 32 cycles -> state=0 and run_time=1; no dec_m/inc_m pulses.
- SET_M, increment and decrement pressed on the same cycle -> no inc_m or dec_m. Time_set press -> state=0.
